// File: rtl/nf10_axis_pkt_buffer_if.sv
// nf10_axis_pkt_buffer_if
// AXI4-Stream beat bundle used on both sides of the packet buffer.
// The master modport drives a stream and the slave modport receives it.
interface nf10_axis_pkt_buffer_if #(
  parameter int DATA_WIDTH = 64
) ();

  logic                      tvalid;
  logic                      tready;
  logic [DATA_WIDTH-1:0]     tdata;
  logic [(DATA_WIDTH/8)-1:0] tstrb;
  logic                      tlast;

  modport master (
    output tvalid,
    input  tready,
    output tdata,
    output tstrb,
    output tlast
  );

  modport slave (
    input  tvalid,
    output tready,
    input  tdata,
    input  tstrb,
    input  tlast
  );

endinterface

// File: rtl/nf10_axis_pkt_buffer.sv
// nf10_axis_pkt_buffer
// Store-and-forward buffer: accepts one beat per cycle without ever
// stalling the upstream core, releases only fully received packets and
// silently drops any packet that runs out of room.
// Optional feature macro: PKT_BUFFER_STATS_EN builds the saturating
// forwarded/dropped packet counters; without it both counters read 0.
module nf10_axis_pkt_buffer #(
  parameter int C_S_AXIS_DATA_WIDTH = 64,
  parameter int C_M_AXIS_DATA_WIDTH = 64,
  parameter int C_DEPTH_LOG2        = 9,
  parameter int C_CNT_WIDTH         = 32
) (
  input  logic                   aclk,
  input  logic                   areset,
  nf10_axis_pkt_buffer_if.slave  s_axis,
  nf10_axis_pkt_buffer_if.master m_axis,
  output logic [C_CNT_WIDTH-1:0] pkt_fwd_count,
  output logic [C_CNT_WIDTH-1:0] pkt_drop_count
);

  localparam int PTR_W     = C_DEPTH_LOG2 + 1;
  localparam int S_STRB_W  = C_S_AXIS_DATA_WIDTH / 8;
  localparam int M_STRB_W  = C_M_AXIS_DATA_WIDTH / 8;
  localparam int ENTRY_W   = C_S_AXIS_DATA_WIDTH + S_STRB_W + 1;
  localparam int M_ENTRY_W = C_M_AXIS_DATA_WIDTH + M_STRB_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_PKT,
    WR_DROP
  } wrState_e;

  wrState_e             wrState_q, wrState_d;
  logic [PTR_W-1:0]     wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]     wrCommit_q, wrCommit_d;
  logic [PTR_W-1:0]     rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]     used;
  logic                 tready_q;
  logic                 accept;
  logic                 full;
  logic                 wrEn;
  logic                 fwdInc;
  logic                 dropInc;

  logic [ENTRY_W-1:0]   mem [0:(1<<C_DEPTH_LOG2)-1];
  logic [ENTRY_W-1:0]   ramEntry_q;
  logic                 ramValid_q, ramValid_d;
  logic                 issue;

  logic [M_ENTRY_W-1:0] slot0_q, slot0_d;
  logic [M_ENTRY_W-1:0] slot1_q, slot1_d;
  logic [1:0]           skidCnt_q, skidCnt_d;
  logic [1:0]           keepCnt;
  logic [2:0]           occAfterPop;
  logic                 pop;

  assign accept = s_axis.tvalid & tready_q;
  assign used   = wrPtr_q - rdPtr_q;
  assign full   = used[C_DEPTH_LOG2];

  assign s_axis.tready = tready_q;
  assign m_axis.tvalid = (skidCnt_q != 2'd0);
  assign m_axis.tlast  = slot0_q[M_ENTRY_W-1];
  assign m_axis.tstrb  = slot0_q[C_M_AXIS_DATA_WIDTH +: M_STRB_W];
  assign m_axis.tdata  = slot0_q[C_M_AXIS_DATA_WIDTH-1:0];

  // Write FSM: append beats to the open packet, commit on tlast, and on
  // the first beat that finds no room rewind to the last commit point and
  // swallow the rest of that packet.
  always_comb begin
    wrState_d  = wrState_q;
    wrPtr_d    = wrPtr_q;
    wrCommit_d = wrCommit_q;
    wrEn       = 1'b0;
    fwdInc     = 1'b0;
    dropInc    = 1'b0;
    if (accept) begin
      case (wrState_q)
        WR_IDLE, WR_PKT: begin
          if (!full) begin
            wrEn    = 1'b1;
            wrPtr_d = wrPtr_q + PTR_ONE;
            if (s_axis.tlast) begin
              wrCommit_d = wrPtr_q + PTR_ONE;
              fwdInc     = 1'b1;
              wrState_d  = WR_IDLE;
            end else begin
              wrState_d = WR_PKT;
            end
          end else begin
            wrPtr_d = wrCommit_q;
            if (s_axis.tlast) begin
              dropInc   = 1'b1;
              wrState_d = WR_IDLE;
            end else begin
              wrState_d = WR_DROP;
            end
          end
        end
        WR_DROP: begin
          if (s_axis.tlast) begin
            dropInc   = 1'b1;
            wrState_d = WR_IDLE;
          end
        end
        default: wrState_d = WR_IDLE;
      endcase
    end
  end

  // Read prefetch: at most two beats live between the RAM read register
  // and the skid, so a new read is issued only when one of those two
  // places will be free after this cycle's output handshake.
  always_comb begin
    slot0_d     = slot0_q;
    slot1_d     = slot1_q;
    pop         = (skidCnt_q != 2'd0) && m_axis.tready;
    keepCnt     = skidCnt_q - {1'b0, pop};
    occAfterPop = {1'b0, keepCnt} + {2'b00, ramValid_q};
    issue       = (rdPtr_q != wrCommit_q) && (occAfterPop < 3'd2);
    if (pop) begin
      slot0_d = slot1_q;
    end
    if (ramValid_q) begin
      if (keepCnt == 2'd0) begin
        slot0_d = ramEntry_q;
      end else begin
        slot1_d = ramEntry_q;
      end
    end
    skidCnt_d  = keepCnt + {1'b0, ramValid_q};
    rdPtr_d    = issue ? (rdPtr_q + PTR_ONE) : rdPtr_q;
    ramValid_d = issue;
  end

  // Packet storage and its registered read port; no reset needed because
  // only committed entries are ever read and ramValid_q qualifies the data.
  always_ff @(posedge aclk) begin
    if (wrEn) begin
      mem[wrPtr_q[C_DEPTH_LOG2-1:0]] <= {s_axis.tlast, s_axis.tstrb, s_axis.tdata};
    end
    if (issue) begin
      ramEntry_q <= mem[rdPtr_q[C_DEPTH_LOG2-1:0]];
    end
  end

  // Control state: pointers, FSM, prefetch occupancy and the output skid.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wrState_q  <= WR_IDLE;
      wrPtr_q    <= '0;
      wrCommit_q <= '0;
      rdPtr_q    <= '0;
      tready_q   <= 1'b0;
      ramValid_q <= 1'b0;
      slot0_q    <= '0;
      slot1_q    <= '0;
      skidCnt_q  <= 2'd0;
    end else begin
      wrState_q  <= wrState_d;
      wrPtr_q    <= wrPtr_d;
      wrCommit_q <= wrCommit_d;
      rdPtr_q    <= rdPtr_d;
      tready_q   <= 1'b1;
      ramValid_q <= ramValid_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      skidCnt_q  <= skidCnt_d;
    end
  end

`ifdef PKT_BUFFER_STATS_EN
  localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = C_CNT_WIDTH'(1);

  logic [C_CNT_WIDTH-1:0] fwdCnt_q;
  logic [C_CNT_WIDTH-1:0] dropCnt_q;

  // Saturating counters of committed and discarded packets.
  always_ff @(posedge aclk) begin
    if (areset) begin
      fwdCnt_q  <= '0;
      dropCnt_q <= '0;
    end else begin
      if (fwdInc && (fwdCnt_q != '1)) begin
        fwdCnt_q <= fwdCnt_q + CNT_ONE;
      end
      if (dropInc && (dropCnt_q != '1)) begin
        dropCnt_q <= dropCnt_q + CNT_ONE;
      end
    end
  end

  assign pkt_fwd_count  = fwdCnt_q;
  assign pkt_drop_count = dropCnt_q;
`else
  logic unusedStats;
  assign unusedStats    = fwdInc ^ dropInc;
  assign pkt_fwd_count  = '0;
  assign pkt_drop_count = '0;
`endif

endmodule

// File: tb/tb_nf10_axis_pkt_buffer.sv
// tb_nf10_axis_pkt_buffer
// Scoreboard bench for the packet buffer built with a 16-beat store.
// Packets the reference model expects to survive are queued when issued;
// a monitor pops and compares every beat the buffer hands out.
module tb_nf10_axis_pkt_buffer;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  typedef struct packed {
    logic        last;
    logic [7:0]  strb;
    logic [63:0] data;
  } beat_t;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] pktFwdCount;
  logic [31:0] pktDropCount;

  nf10_axis_pkt_buffer_if #(.DATA_WIDTH(64)) sIf ();
  nf10_axis_pkt_buffer_if #(.DATA_WIDTH(64)) mIf ();

  nf10_axis_pkt_buffer #(
    .C_S_AXIS_DATA_WIDTH(64),
    .C_M_AXIS_DATA_WIDTH(64),
    .C_DEPTH_LOG2(DEPTH_LOG2),
    .C_CNT_WIDTH(32)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .s_axis(sIf),
    .m_axis(mIf),
    .pkt_fwd_count(pktFwdCount),
    .pkt_drop_count(pktDropCount)
  );

  // Free-running clock and cycle index used to time-stamp output beats.
  always #5 aclk = ~aclk;

  int unsigned cycle = 0;
  always @(posedge aclk) cycle <= cycle + 1;

  beat_t expQ[$];
  int    acceptLog[$];
  int    cmpCount  = 0;
  int    errCount  = 0;
  int    fwdExp    = 0;
  int    dropExp   = 0;
  int    readyMode = 1;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    cmpCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int expCnt(input int v);
`ifdef PKT_BUFFER_STATS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_fwd_count"}, 128'(pktFwdCount), 128'(expCnt(fwdExp)));
    checkOutput({tag, "_drop_count"}, 128'(pktDropCount), 128'(expCnt(dropExp)));
  endtask

  // One input beat: held from a falling edge until a rising edge sees tready.
  task automatic sendBeat(input logic [63:0] d, input logic [7:0] st, input logic l, input bit gaps);
    bit done = 1'b0;
    int tries = 0;
    if (gaps) begin
      while ($urandom_range(3) == 0) begin
        sIf.tvalid = 1'b0;
        @(negedge aclk);
      end
    end
    sIf.tvalid = 1'b1;
    sIf.tdata  = d;
    sIf.tstrb  = st;
    sIf.tlast  = l;
    while (!done) begin
      done = (sIf.tready == 1'b1);
      @(negedge aclk);
      if (!done) begin
        tries++;
        if (tries > 50) begin
          checkOutput("tready_timeout", 128'(sIf.tready), 128'(1));
          done = 1'b1;
        end
      end
    end
    sIf.tvalid = 1'b0;
  endtask

  // Builds a packet, applies the model's verdict (forward or drop), and
  // sends it. With gate set, waits until the packet surely fits: the RAM
  // never holds more than the beats still expected at the output.
  task automatic applyStimulus(input int len, input bit expectDrop, input bit seqData,
                               input bit gate, input bit gaps);
    beat_t pkt[$];
    int w = 0;
    for (int k = 0; k < len; k++) begin
      beat_t b;
      b.data = seqData ? 64'(k + 1) : {$urandom, $urandom};
      b.strb = seqData ? 8'hFF : 8'($urandom);
      b.last = (k == len - 1);
      pkt.push_back(b);
    end
    if (gate && !expectDrop) begin
      while ((expQ.size() + len > DEPTH) && (w < 2000)) begin
        @(negedge aclk);
        w++;
      end
      if (w >= 2000) checkOutput("gate_timeout", 128'(expQ.size()), 128'(DEPTH - len));
    end
    if (expectDrop) begin
      dropExp++;
    end else begin
      fwdExp++;
      foreach (pkt[i]) expQ.push_back(pkt[i]);
    end
    foreach (pkt[i]) sendBeat(pkt[i].data, pkt[i].strb, pkt[i].last, gaps);
  endtask

  task automatic waitDrain();
    int w = 0;
    while ((expQ.size() != 0) && (w < 3000)) begin
      @(negedge aclk);
      w++;
    end
    checkOutput("drain", 128'(expQ.size()), 128'(0));
    repeat (10) @(negedge aclk);
  endtask

  task automatic doReset();
    @(negedge aclk);
    areset     = 1'b1;
    sIf.tvalid = 1'b0;
    @(negedge aclk);
    checkOutput("rst_m_tvalid", 128'(mIf.tvalid), 128'(0));
    checkOutput("rst_m_tdata", 128'(mIf.tdata), 128'(0));
    checkOutput("rst_m_tstrb", 128'(mIf.tstrb), 128'(0));
    checkOutput("rst_m_tlast", 128'(mIf.tlast), 128'(0));
    checkOutput("rst_s_tready", 128'(sIf.tready), 128'(0));
    checkOutput("rst_fwd_count", 128'(pktFwdCount), 128'(0));
    checkOutput("rst_drop_count", 128'(pktDropCount), 128'(0));
    expQ.delete();
    fwdExp  = 0;
    dropExp = 0;
    areset  = 1'b0;
    @(negedge aclk);
    checkOutput("tready_after_reset", 128'(sIf.tready), 128'(1));
  endtask

  // Output ready driver: low, high, toggling or random per readyMode.
  initial begin : readyDriver
    mIf.tready = 1'b1;
    forever begin
      @(negedge aclk);
      case (readyMode)
        0:       mIf.tready = 1'b0;
        1:       mIf.tready = 1'b1;
        2:       mIf.tready = ~mIf.tready;
        default: mIf.tready = 1'($urandom_range(1));
      endcase
    end
  end

  // Monitor: compares each accepted beat with the scoreboard head and
  // checks that a stalled beat stays unchanged until it is taken.
  initial begin : monitor
    beat_t held;
    beat_t act;
    bit    holding = 1'b0;
    forever begin
      @(negedge aclk);
      #2;
      if (areset) begin
        holding = 1'b0;
      end else begin
        act.data = mIf.tdata;
        act.strb = mIf.tstrb;
        act.last = mIf.tlast;
        if (holding) begin
          checkOutput("stable", 128'({mIf.tvalid, act}), 128'({1'b1, held}));
        end
        holding = 1'b0;
        if (mIf.tvalid) begin
          if (mIf.tready) begin
            acceptLog.push_back(int'(cycle));
            if (expQ.size() == 0) begin
              cmpCount++;
              errCount++;
              $display("[TB] FAIL unexpected_beat: got %0h, expected no beat", act);
            end else begin
              checkOutput("beat", 128'(act), 128'(expQ.pop_front()));
            end
          end else begin
            holding = 1'b1;
            held    = act;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : mainSeq
    sIf.tvalid = 1'b0;
    sIf.tdata  = '0;
    sIf.tstrb  = '0;
    sIf.tlast  = 1'b0;
    repeat (2) @(negedge aclk);
    doReset();

    $display("[TB] single packet and latency");
    readyMode = 1;
    applyStimulus(4, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("latency_edge_n", 128'(mIf.tvalid), 128'(0));
    @(negedge aclk);
    checkOutput("latency_edge_n1", 128'(mIf.tvalid), 128'(0));
    @(negedge aclk);
    checkOutput("latency_edge_n2", 128'(mIf.tvalid), 128'(1));
    checkOutput("latency_first_data", 128'(mIf.tdata), 128'(1));
    waitDrain();
    checkCounters("single");

    $display("[TB] back-to-back packets under toggling backpressure");
    readyMode = 2;
    for (int p = 0; p < 3; p++) applyStimulus(8, 1'b0, 1'b0, 1'b0, 1'b0);
    waitDrain();
    checkCounters("b2b_toggle");

    $display("[TB] back-to-back packets at full rate");
    readyMode = 1;
    acceptLog.delete();
    for (int p = 0; p < 3; p++) applyStimulus(8, 1'b0, 1'b0, 1'b0, 1'b0);
    waitDrain();
    checkOutput("fullrate_beats", 128'(acceptLog.size()), 128'(24));
    if (acceptLog.size() == 24) begin
      checkOutput("fullrate_no_bubble", 128'(acceptLog[23] - acceptLog[0]), 128'(23));
    end

    $display("[TB] overflow");
    doReset();
    readyMode = 0;
    applyStimulus(10, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (5) @(negedge aclk);
    applyStimulus(10, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge aclk);
    checkCounters("overflow_held");
    readyMode = 1;
    waitDrain();
    checkCounters("overflow");

    $display("[TB] fill then overflow by a short packet");
    readyMode = 0;
    applyStimulus(8, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (5) @(negedge aclk);
    applyStimulus(8, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (5) @(negedge aclk);
    applyStimulus(4, 1'b1, 1'b0, 1'b0, 1'b0);
    readyMode = 1;
    waitDrain();
    checkCounters("fill");

    $display("[TB] oversize packet and exact-fit packet");
    doReset();
    readyMode = 1;
    applyStimulus(17, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(2, 1'b0, 1'b0, 1'b1, 1'b0);
    waitDrain();
    checkCounters("oversize");
    readyMode = 0;
    applyStimulus(16, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge aclk);
    readyMode = 1;
    waitDrain();
    checkCounters("exact_fit");

    $display("[TB] reset in the middle of a packet");
    for (int k = 0; k < 3; k++) sendBeat(64'($urandom), 8'hFF, 1'b0, 1'b0);
    doReset();
    applyStimulus(2, 1'b0, 1'b0, 1'b1, 1'b0);
    waitDrain();
    checkCounters("mid_reset");

    $display("[TB] random traffic");
    readyMode = 3;
    for (int p = 0; p < 40; p++) begin
      applyStimulus($urandom_range(12, 1), 1'b0, 1'b0, 1'b1, 1'b1);
    end
    waitDrain();
    checkCounters("random");

    $display("End of test - %0d assertions evaluated, %0d failures", cmpCount, errCount);
    $finish;
  end

endmodule
